// File: rtl/spi_rx_pkg.sv
// spi_rx_pkg: shared types and constants for the SPI slave receiver
// Contents: state_e (IDLE/SHIFT/PUBLISH receive FSM states), SYNC_DEPTH (flops per async input)
package spi_rx_pkg;
    localparam int SYNC_DEPTH = 2;
    typedef enum logic [1:0] {IDLE, SHIFT, PUBLISH} state_e;
endpackage

// File: rtl/spi_slave_rx_if.sv
// spi_slave_rx_if: SPI pins plus consumer handshake of the SPI slave receiver
// Signals: i_sck/i_mosi/i_ss_n SPI pins, i_ack consumer acknowledge,
//          o_data/o_valid published frame, o_busy frame in progress, o_overrun/o_frame_err pulses
// Modports: master (SPI master + consumer side), slave (receiver side)
interface spi_slave_rx_if #(
    parameter int DATA_W = 8
);
    logic              i_sck;
    logic              i_mosi;
    logic              i_ss_n;
    logic              i_ack;
    logic [DATA_W-1:0] o_data;
    logic              o_valid;
    logic              o_busy;
    logic              o_overrun;
    logic              o_frame_err;
    modport master (
        output i_sck, i_mosi, i_ss_n, i_ack,
        input  o_data, o_valid, o_busy, o_overrun, o_frame_err
    );
    modport slave (
        input  i_sck, i_mosi, i_ss_n, i_ack,
        output o_data, o_valid, o_busy, o_overrun, o_frame_err
    );
endinterface

// File: rtl/sync_edge_det.sv
// sync_edge_det: SYNC_DEPTH-flop synchronizer with rise/fall pulse detection on the synced level
// Ports: i_clk clock, i_rst_n async active-low reset, i_async raw input,
//        o_sync synchronized level, o_rise/o_fall one-cycle edge pulses
module sync_edge_det
    import spi_rx_pkg::*;
#(
    parameter logic RST_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);
    logic [SYNC_DEPTH-1:0] sync_q;
    logic                  prev_q;
    logic [SYNC_DEPTH:0]   warm_q;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q <= {SYNC_DEPTH{RST_VAL}};
            prev_q <= RST_VAL;
            warm_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_DEPTH-2:0], i_async};
            prev_q <= sync_q[SYNC_DEPTH-1];
            warm_q <= {warm_q[SYNC_DEPTH-1:0], 1'b1};
        end
    end
    assign o_sync = sync_q[SYNC_DEPTH-1];
    // Edges are suppressed until the pipeline holds only real samples, so the
    // reset idle level never fakes an edge (e.g. ss_n held low across reset).
    assign o_rise = &warm_q & o_sync & ~prev_q;
    assign o_fall = &warm_q & ~o_sync & prev_q;
endmodule

// File: rtl/spi_slave_rx.sv
// spi_slave_rx: SPI slave receiver publishing DATA_W-bit frames with a valid/ack handshake
// Ports: i_clk system clock (>= 4x SCK), i_rst_n async active-low reset,
//        bus (spi_slave_rx_if.slave): i_sck/i_mosi/i_ss_n SPI pins, i_ack consumer ack,
//        o_data/o_valid last frame and unread flag, o_busy frame in progress,
//        o_overrun unread data overwritten (pulse), o_frame_err short frame (pulse)
// Build option: define SPI_RX_FRAME_ERR_EN to pulse o_frame_err on discarded short frames
module spi_slave_rx
    import spi_rx_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int CPOL      = 0,
    parameter int CPHA      = 0,
    parameter int MSB_FIRST = 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    spi_slave_rx_if.slave bus
);
    localparam int               CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(DATA_W);

    logic sck_lvl_unused, sck_rise, sck_fall;
    logic ss_lvl_unused, ss_rise, ss_fall;
    logic mosi, mosi_rise_unused, mosi_fall_unused;

    sync_edge_det #(.RST_VAL(1'(CPOL))) u_sck (
        .i_clk, .i_rst_n, .i_async(bus.i_sck),
        .o_sync(sck_lvl_unused), .o_rise(sck_rise), .o_fall(sck_fall)
    );
    sync_edge_det #(.RST_VAL(1'b1)) u_ss (
        .i_clk, .i_rst_n, .i_async(bus.i_ss_n),
        .o_sync(ss_lvl_unused), .o_rise(ss_rise), .o_fall(ss_fall)
    );
    sync_edge_det #(.RST_VAL(1'b0)) u_mosi (
        .i_clk, .i_rst_n, .i_async(bus.i_mosi),
        .o_sync(mosi), .o_rise(mosi_rise_unused), .o_fall(mosi_fall_unused)
    );

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d, data_q, data_d;
    logic              valid_q, valid_d, busy_q, busy_d, ovr_q, ovr_d;
    logic              sample, full;

    // Mode 0 and 3 sample on rising SCK, modes 1 and 2 on falling SCK.
    assign sample = ((CPOL ^ CPHA) != 0) ? sck_fall : sck_rise;
    assign full   = (cnt_q == FULL);

`ifdef SPI_RX_FRAME_ERR_EN
    logic ferr_q, ferr_d;
    assign bus.o_frame_err = ferr_q;
`else
    assign bus.o_frame_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q & ~bus.i_ack;
        ovr_d   = 1'b0;
`ifdef SPI_RX_FRAME_ERR_EN
        ferr_d  = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (ss_fall) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    shift_d = '0;
                end
            end
            SHIFT: begin
                if (sample) begin
                    shift_d = (MSB_FIRST != 0) ? {shift_q[DATA_W-2:0], mosi} : {mosi, shift_q[DATA_W-1:1]};
                    cnt_d   = full ? cnt_q : cnt_q + CNT_W'(1);
                end
                if (ss_rise) state_d = PUBLISH;
            end
            PUBLISH: begin
                state_d = IDLE;
                if (full) begin
                    data_d  = shift_q;
                    valid_d = 1'b1;
                    ovr_d   = valid_q & ~bus.i_ack;
                end
`ifdef SPI_RX_FRAME_ERR_EN
                else ferr_d = 1'b1;
`endif
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == SHIFT);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef SPI_RX_FRAME_ERR_EN
            ferr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            ovr_q   <= ovr_d;
`ifdef SPI_RX_FRAME_ERR_EN
            ferr_q  <= ferr_d;
`endif
        end
    end

    assign bus.o_data    = data_q;
    assign bus.o_valid   = valid_q;
    assign bus.o_busy    = busy_q;
    assign bus.o_overrun = ovr_q;
endmodule
